// File: rtl/tl_plic_lite.sv
// Level-triggered PLIC with a TileLink-UL register port; D response one cycle after A fires, irq_tgt registered.
// One request outstanding: a_ready drops while d_valid is held waiting for d_ready.
module tl_plic_lite #(
  parameter int NSRC        = 3,
  parameter int NTGT        = 2,
  parameter int PRIO_W      = 3,
  parameter int SRC_W       = 11,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [NSRC-1:0]  irq_src,
  output logic [NTGT-1:0]  irq_tgt,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [2:0]       a_opcode,
  input  logic [1:0]       a_size,
  input  logic [SRC_W-1:0] a_source,
  input  logic [15:0]      a_address,
  input  logic [3:0]       a_mask,
  input  logic [31:0]      a_data,
  output logic             d_valid,
  input  logic             d_ready,
  output logic [2:0]       d_opcode,
  output logic [1:0]       d_size,
  output logic [SRC_W-1:0] d_source,
  output logic [31:0]      d_data
);

  localparam int IDW = 5;
  localparam logic [NSRC:0] EN_MASK = {{NSRC{1'b1}}, 1'b0};

  logic [NSRC-1:0]   src_s;
  logic [PRIO_W-1:0] prio_q [NSRC+1];
  logic [NSRC:0]     en_q   [NTGT];
  logic [PRIO_W-1:0] thr_q  [NTGT];
  logic [NSRC:0]     pend_q, insv_q, pend_nxt, insv_nxt;
  logic [IDW-1:0]    best_id [NTGT];
  logic [PRIO_W-1:0] best_p  [NTGT];
  logic [NTGT-1:0]   any_cand;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign src_s = irq_src;
    end else begin : g_sync
      logic [NSRC-1:0] sync_q [SYNC_STAGES];
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
          sync_q[0] <= irq_src;
          for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
      end
      assign src_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Ascending scan with strict '>' keeps the lowest ID on priority ties.
  always_comb begin
    for (int t = 0; t < NTGT; t++) begin
      best_id[t]  = '0;
      best_p[t]   = '0;
      any_cand[t] = 1'b0;
      for (int i = 1; i <= NSRC; i++) begin
        if (pend_q[i] && en_q[t][i] && (prio_q[i] > thr_q[t])) begin
          any_cand[t] = 1'b1;
          if (best_id[t] == '0 || prio_q[i] > best_p[t]) begin
            best_id[t] = IDW'(i);
            best_p[t]  = prio_q[i];
          end
        end
      end
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [31:0] m);
    return (old & ~m) | (nw & m);
  endfunction

  logic        fire, is_get, is_put, wr_en;
  logic        hit_prio, hit_pend, hit_en, hit_thr, hit_clm;
  int          sel_i, sel_t, page, word;
  logic [31:0] wmask, rdata;

  assign a_ready = !d_valid;
  assign fire    = a_valid && a_ready;
  assign is_get  = (a_opcode == 3'd4);
  assign is_put  = (a_opcode == 3'd0) || (a_opcode == 3'd1);
  assign wr_en   = fire && is_put;
  assign wmask   = {{8{a_mask[3]}}, {8{a_mask[2]}}, {8{a_mask[1]}}, {8{a_mask[0]}}};
  assign page    = int'(a_address[15:12]);
  assign word    = int'(a_address[11:2]);

  always_comb begin
    hit_prio = 1'b0; hit_pend = 1'b0; hit_en = 1'b0; hit_thr = 1'b0; hit_clm = 1'b0;
    sel_i = 0; sel_t = 0;
    if (a_size == 2'd2) begin
      if (page == 0) begin
        hit_prio = (word >= 1) && (word <= NSRC);
        sel_i    = word;
      end else if (page == 1) begin
        hit_pend = (word == 0);
      end else if (page == 2) begin
        sel_t  = word / 32;
        hit_en = (word % 32 == 0) && (sel_t < NTGT);
      end else begin
        sel_t   = page - 3;
        hit_thr = (sel_t < NTGT) && (word == 0);
        hit_clm = (sel_t < NTGT) && (word == 1);
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (hit_pend) rdata = 32'(pend_q);
    for (int i = 1; i <= NSRC; i++)
      if (hit_prio && sel_i == i) rdata = 32'(prio_q[i]);
    for (int t = 0; t < NTGT; t++) begin
      if (sel_t == t) begin
        if (hit_en)  rdata = 32'(en_q[t]);
        if (hit_thr) rdata = 32'(thr_q[t]);
        if (hit_clm) rdata = 32'(best_id[t]);
      end
    end
  end

  // Gateway set is blocked by pending/in-service, so a claim clear or a
  // same-cycle complete naturally wins and any re-pend lands a cycle later.
  always_comb begin
    pend_nxt = pend_q | ({src_s, 1'b0} & ~pend_q & ~insv_q);
    insv_nxt = insv_q;
    for (int t = 0; t < NTGT; t++) begin
      for (int i = 1; i <= NSRC; i++) begin
        if (fire && is_get && hit_clm && sel_t == t && best_id[t] == IDW'(i)) begin
          pend_nxt[i] = 1'b0;
          insv_nxt[i] = 1'b1;
        end
        if (wr_en && hit_clm && a_mask[0] && sel_t == t && (a_data & wmask) == 32'(i)
            && en_q[t][i] && insv_q[i])
          insv_nxt[i] = 1'b0;
      end
    end
    pend_nxt[0] = 1'b0;
    insv_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i <= NSRC; i++) prio_q[i] <= '0;
      for (int t = 0; t < NTGT; t++) begin
        en_q[t]  <= '0;
        thr_q[t] <= '0;
      end
      pend_q   <= '0;
      insv_q   <= '0;
      irq_tgt  <= '0;
      d_valid  <= 1'b0;
      d_opcode <= '0;
      d_size   <= '0;
      d_source <= '0;
      d_data   <= '0;
    end else begin
      pend_q  <= pend_nxt;
      insv_q  <= insv_nxt;
      irq_tgt <= any_cand;
      for (int i = 1; i <= NSRC; i++)
        if (wr_en && hit_prio && sel_i == i)
          prio_q[i] <= PRIO_W'(merge(32'(prio_q[i]), a_data, wmask));
      for (int t = 0; t < NTGT; t++) begin
        if (wr_en && hit_en && sel_t == t)
          en_q[t] <= (NSRC+1)'(merge(32'(en_q[t]), a_data, wmask)) & EN_MASK;
        if (wr_en && hit_thr && sel_t == t)
          thr_q[t] <= PRIO_W'(merge(32'(thr_q[t]), a_data, wmask));
      end
      if (fire) begin
        d_valid  <= 1'b1;
        d_opcode <= is_get ? 3'd1 : 3'd0;
        d_size   <= a_size;
        d_source <= a_source;
        d_data   <= is_get ? rdata : '0;
      end else if (d_valid && d_ready) begin
        d_valid <= 1'b0;
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^a_address[1:0];

endmodule

// File: tb/tb_tl_plic_lite.sv
// Directed bench for tl_plic_lite: register access, gateway, arbitration, claim/complete, handshake.
module tb_tl_plic_lite;
  logic        clock = 1'b0;
  logic        reset_n;
  logic [2:0]  irq_src;
  logic [1:0]  irq_tgt;
  logic        a_valid, a_ready, d_valid, d_ready;
  logic [2:0]  a_opcode, d_opcode;
  logic [1:0]  a_size, d_size;
  logic [10:0] a_source, d_source;
  logic [15:0] a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data, d_data;

  int total = 0;
  int bad   = 0;
  logic [10:0] src_ctr = 11'h10;
  logic [31:0] rd;

  always #5 clock = ~clock;

  tl_plic_lite dut (
    .clock(clock), .reset_n(reset_n), .irq_src(irq_src), .irq_tgt(irq_tgt),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_size(a_size),
    .a_source(a_source), .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_size(d_size),
    .d_source(d_source), .d_data(d_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic xact(input logic [2:0] op, input logic [15:0] addr, input logic [31:0] data,
                      input logic [3:0] mask, input logic [1:0] size, output logic [31:0] r);
    int n;
    @(negedge clock);
    a_valid = 1'b1; a_opcode = op; a_address = addr; a_data = data;
    a_mask = mask; a_size = size; a_source = src_ctr; d_ready = 1'b1;
    n = 0;
    while (!a_ready && n < 10) begin @(negedge clock); n++; end
    chk("a_ready_wait", 32'(a_ready), 32'd1);
    @(posedge clock); #1;
    a_valid = 1'b0;
    chk("d_valid", 32'(d_valid), 32'd1);
    chk("d_opcode", 32'(d_opcode), (op == 3'd4) ? 32'd1 : 32'd0);
    chk("d_source", 32'(d_source), 32'(src_ctr));
    r = d_data;
    src_ctr = src_ctr + 11'd1;
    @(posedge clock); #1;
  endtask

  task automatic wr(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] mask);
    logic [31:0] r;
    xact(3'd0, addr, data, mask, 2'd2, r);
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] addr, input logic [31:0] exp);
    logic [31:0] r;
    xact(3'd4, addr, 32'h0, 4'hF, 2'd2, r);
    chk(tag, r, exp);
  endtask

  task automatic wait_cycles(input int n);
    for (int k = 0; k < n; k++) @(negedge clock);
  endtask

  initial begin
    int n;
    logic seen;
    reset_n = 1'b0; irq_src = '0; a_valid = 1'b0; a_opcode = '0; a_size = 2'd2;
    a_source = '0; a_address = '0; a_mask = '0; a_data = '0; d_ready = 1'b1;
    wait_cycles(3);
    reset_n = 1'b1;
    @(negedge clock);

    // 1: reset state
    chk("rst_irq", 32'(irq_tgt), 32'd0);
    chk("rst_a_ready", 32'(a_ready), 32'd1);
    chk("rst_d_valid", 32'(d_valid), 32'd0);
    rd_chk("rst_prio1", 16'h0004, 0);
    rd_chk("rst_prio2", 16'h0008, 0);
    rd_chk("rst_prio3", 16'h000C, 0);
    rd_chk("rst_pend", 16'h1000, 0);
    rd_chk("rst_en0", 16'h2000, 0);
    rd_chk("rst_en1", 16'h2080, 0);
    rd_chk("rst_thr0", 16'h3000, 0);
    rd_chk("rst_thr1", 16'h4000, 0);
    rd_chk("rst_clm0", 16'h3004, 0);
    rd_chk("rst_clm1", 16'h4004, 0);

    // 2: single source through claim/complete
    wr(16'h0008, 32'd3, 4'hF);
    wr(16'h2000, 32'h4, 4'hF);
    wr(16'h3000, 32'd0, 4'hF);
    @(negedge clock);
    irq_src[1] = 1'b1;
    seen = 1'b0; n = 0;
    while (!seen && n < 8) begin @(negedge clock); n++; seen = irq_tgt[0]; end
    chk("irq_latency_ok", 32'(seen && n <= 4), 32'd1);
    chk("irq_tgt1_off", 32'(irq_tgt[1]), 32'd0);
    rd_chk("claim_id2", 16'h3004, 32'd2);
    chk("irq_after_claim", 32'(irq_tgt[0]), 32'd0);
    rd_chk("pend_after_claim", 16'h1000, 32'h0);
    wr(16'h3004, 32'd2, 4'hF);
    rd_chk("pend_repend", 16'h1000, 32'h4);
    chk("irq_repend", 32'(irq_tgt[0]), 32'd1);
    irq_src[1] = 1'b0;
    wait_cycles(4);
    rd_chk("pend_sticky", 16'h1000, 32'h4);
    rd_chk("claim_id2b", 16'h3004, 32'd2);
    wr(16'h3004, 32'd2, 4'hF);
    rd_chk("pend_low_line", 16'h1000, 32'h0);

    // 3: tie broken by lowest ID
    wr(16'h0004, 32'd5, 4'hF);
    wr(16'h000C, 32'd5, 4'hF);
    wr(16'h2000, 32'hA, 4'hF);
    irq_src = 3'b101;
    wait_cycles(5);
    rd_chk("pend_1_3", 16'h1000, 32'hA);
    rd_chk("claim_tie_1", 16'h3004, 32'd1);
    rd_chk("claim_next_3", 16'h3004, 32'd3);
    rd_chk("claim_none", 16'h3004, 32'd0);

    // 4: threshold gating
    wr(16'h3004, 32'd1, 4'hF);
    wait_cycles(2);
    chk("irq_before_thr", 32'(irq_tgt[0]), 32'd1);
    wr(16'h3000, 32'd5, 4'hF);
    chk("irq_thr5", 32'(irq_tgt[0]), 32'd0);
    wr(16'h3000, 32'd4, 4'hF);
    chk("irq_thr4", 32'(irq_tgt[0]), 32'd1);

    // 5: invalid completes leave ID 3 in service
    wr(16'h3004, 32'd0, 4'hF);
    wr(16'h3004, 32'd4, 4'hF);
    wr(16'h4004, 32'd3, 4'hF);
    wr(16'h3004, 32'd3, 4'hE);
    wait_cycles(2);
    rd_chk("pend_bad_cmpl", 16'h1000, 32'h2);
    wr(16'h3004, 32'd3, 4'hF);
    rd_chk("pend_good_cmpl", 16'h1000, 32'hA);

    // 6: backpressure, size/mask/range handling
    @(negedge clock);
    a_valid = 1'b1; a_opcode = 3'd4; a_address = 16'h0004; a_size = 2'd2;
    a_mask = 4'hF; a_source = 11'h155; d_ready = 1'b0;
    @(posedge clock); #1;
    a_valid = 1'b0; a_source = 11'h0AA; a_address = 16'h0008;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("hold_payload", {d_valid, a_ready, d_opcode, d_size, d_source, 14'(d_data)},
          {1'b1, 1'b0, 3'd1, 2'd2, 11'h155, 14'd5});
    end
    d_ready = 1'b1;
    @(posedge clock); #1;
    chk("release_dv", 32'(d_valid), 32'd0);
    chk("release_ar", 32'(a_ready), 32'd1);
    xact(3'd0, 16'h0004, 32'd7, 4'hF, 2'd1, rd);
    rd_chk("prio1_size1", 16'h0004, 32'd5);
    xact(3'd4, 16'h0004, 32'h0, 4'hF, 2'd1, rd);
    chk("get_size1_data", rd, 32'd0);
    wr(16'h0008, 32'd7, 4'hE);
    rd_chk("prio2_mask", 16'h0008, 32'd3);
    wr(16'h0008, 32'h0E, 4'hF);
    rd_chk("prio2_trunc", 16'h0008, 32'd6);
    wr(16'h5000, 32'd3, 4'hF);
    rd_chk("thr_t2_unmapped", 16'h5000, 32'd0);
    rd_chk("unmapped_1004", 16'h1004, 32'd0);
    rd_chk("prio_i4", 16'h0010, 32'd0);
    wr(16'h0000, 32'd7, 4'hF);
    rd_chk("prio0", 16'h0000, 32'd0);
    wr(16'h2080, 32'hF, 4'hF);
    rd_chk("en1_bit0", 16'h2080, 32'hE);
    wait_cycles(1);
    chk("irq_tgt1_on", 32'(irq_tgt), 32'h3);

    // Reset during an outstanding D beat
    irq_src = '0;
    @(negedge clock);
    a_valid = 1'b1; a_opcode = 3'd4; a_address = 16'h1000; d_ready = 1'b0;
    @(posedge clock); #1;
    a_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("arst_irq", 32'(irq_tgt), 32'd0);
    chk("arst_dv", 32'(d_valid), 32'd0);
    chk("arst_ar", 32'(a_ready), 32'd1);
    wait_cycles(2);
    reset_n = 1'b1;
    rd_chk("arst_pend", 16'h1000, 32'd0);
    rd_chk("arst_prio1", 16'h0004, 32'd0);
    rd_chk("arst_en0", 16'h2000, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
